// File: rtl/pulse_meter_pkg.sv
// Shared types and constants for the pulse meter measurement blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pulse_meter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_FIRE,
        ST_GUARD,
        ST_REPORT
    } state_t;

    localparam int DEF_CNT_W    = 38;
    localparam int DEF_AVG_LOG2 = 2;
    localparam int DEF_SHOTS    = 1 << DEF_AVG_LOG2;

    // Number of shots averaged for a given log2 shot count.
    function automatic int shots_of(input int avg_log2);
        return 1 << avg_log2;
    endfunction

endpackage

// File: rtl/echo_edge_detector.sv
// Rising-edge strobe on an already-synchronised echo level.
// Latency: combinational strobe in the cycle the level first reads high.
// Backpressure: none; free-running.
//
// Ports:
//   i_Clk, i_Rst : clock, synchronous active-high reset
//   i_Echo       : echo level, synchronous to i_Clk
//   o_Rise       : high for one cycle when i_Echo goes 0 -> 1
module echo_edge_detector (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Echo,
    output logic o_Rise
);

    logic echo_d;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            echo_d <= 1'b0;
        end else begin
            echo_d <= i_Echo;
        end
    end

    assign o_Rise = i_Echo & ~echo_d;

endmodule

// File: rtl/pulse_measure_sequencer.sv
// Sequences 2^AVG_LOG2 fire/echo shots and reports the averaged tick count or a timeout.
// Latency: o_Done follows the last shot's echo rise by GUARD_TICKS+1 cycles.
// Backpressure: none; i_Start outside IDLE is dropped, results held until the next start.
//
// Ports:
//   i_Clk, i_Rst : clock, synchronous active-high reset
//   i_Start      : single-cycle measurement request (IDLE only)
//   i_Echo       : returned signal, synchronised level
//   o_Fire       : emitter enable, high only in FIRE
//   o_Busy       : high outside IDLE
//   o_Done       : one-cycle strobe at the end of a measurement
//   o_Timeout    : result flag, valid from o_Done
//   o_Time       : averaged ticks, valid from o_Done
module pulse_measure_sequencer
    import pulse_meter_pkg::*;
#(
    parameter int CNT_W         = DEF_CNT_W,
    parameter int TIMEOUT_TICKS = 1000,
    parameter int GUARD_TICKS   = 10,
    parameter int AVG_LOG2      = DEF_AVG_LOG2
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Start,
    input  logic             i_Echo,
    output logic             o_Fire,
    output logic             o_Busy,
    output logic             o_Done,
    output logic             o_Timeout,
    output logic [CNT_W-1:0] o_Time
);

    localparam int SHOTS  = shots_of(AVG_LOG2);
    localparam int SHOT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int SUM_W  = CNT_W + AVG_LOG2;

    localparam logic [CNT_W-1:0]  TMO_LAST   = CNT_W'(TIMEOUT_TICKS - 1);
    localparam logic [CNT_W-1:0]  GUARD_LAST = CNT_W'(GUARD_TICKS - 1);
    localparam logic [SHOT_W-1:0] SHOT_LAST  = SHOT_W'(SHOTS - 1);

    state_t              state;
    logic [CNT_W-1:0]    cnt;    // ARM wait ticks, FIRE tick t, or GUARD ticks
    logic [SHOT_W-1:0]   shot;
    logic [SUM_W-1:0]    sum;
    logic                abort;  // a shot timed out; the drain ends in a timeout report
    logic                echo_rise;

    echo_edge_detector u_edge (
        .i_Clk  (i_Clk),
        .i_Rst  (i_Rst),
        .i_Echo (i_Echo),
        .o_Rise (echo_rise)
    );

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            shot      <= '0;
            sum       <= '0;
            abort     <= 1'b0;
            o_Fire    <= 1'b0;
            o_Busy    <= 1'b0;
            o_Done    <= 1'b0;
            o_Timeout <= 1'b0;
            o_Time    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_Start) begin
                        state     <= ST_ARM;
                        cnt       <= '0;
                        shot      <= '0;
                        sum       <= '0;
                        abort     <= 1'b0;
                        o_Busy    <= 1'b1;
                        o_Timeout <= 1'b0;
                        o_Time    <= '0;
                    end
                end

                // Emitter must see a low echo before it is fired again.
                ST_ARM: begin
                    if (!i_Echo) begin
                        state  <= ST_FIRE;
                        cnt    <= '0;
                        o_Fire <= 1'b1;
                    end else if (cnt == TMO_LAST) begin
                        state <= ST_GUARD;
                        cnt   <= '0;
                        abort <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // A rise on the final tick still counts as a valid shot.
                ST_FIRE: begin
                    if (echo_rise) begin
                        state  <= ST_GUARD;
                        sum    <= sum + SUM_W'(cnt);
                        cnt    <= '0;
                        o_Fire <= 1'b0;
                    end else if (cnt == TMO_LAST) begin
                        state  <= ST_GUARD;
                        cnt    <= '0;
                        abort  <= 1'b1;
                        o_Fire <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_GUARD: begin
                    if (cnt == GUARD_LAST) begin
                        cnt <= '0;
                        if (abort || shot == SHOT_LAST) begin
                            state     <= ST_REPORT;
                            o_Done    <= 1'b1;
                            o_Timeout <= abort;
                            o_Time    <= abort ? '0 : CNT_W'(sum >> AVG_LOG2);
                        end else begin
                            state <= ST_ARM;
                            shot  <= shot + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_REPORT: begin
                    state  <= ST_IDLE;
                    abort  <= 1'b0;
                    o_Done <= 1'b0;
                    o_Busy <= 1'b0;
                end

                default: begin
                    state  <= ST_IDLE;
                    o_Fire <= 1'b0;
                    o_Busy <= 1'b0;
                    o_Done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/pulse_measure_sequencer.md
Name: pulse_measure_sequencer

Overview:
- Sequences one complete propagation-time measurement for the pulse meter.
- Drives the pulse emitter's enable, times the returning echo with a free-running tick counter, and repeats 2^AVG_LOG2 shots.
- Reports the averaged tick count, or flags a timeout.
- Sits between the control/UART front-end (i_Start, results) and the monostable emitter (o_Fire feeds its enable input).

Parameters:
- CNT_W, 38: width of the per-shot tick counter and of o_Time.
- TIMEOUT_TICKS, 1000: maximum ticks allowed in the ARM state and in the FIRE state. Must be < 2^CNT_W.
- GUARD_TICKS, 10: ticks o_Fire is held low between shots so the emitter re-arms. Must be >= 1.
- AVG_LOG2, 2: log2 of shots per measurement. SHOTS = 2^AVG_LOG2.

Ports:
- i_Clk  in  1  clock; reset i_Rst, synchronous, active-high.
- i_Rst  in  1  synchronous active-high reset.
- i_Start  in  1  single-cycle start request. Ignored unless in IDLE.
- i_Echo  in  1  returned signal, already synchronised to i_Clk; level.
- o_Fire  out  1  emitter enable; high only in FIRE.
- o_Busy  out  1  high in every state except IDLE.
- o_Done  out  1  one-cycle strobe when a measurement finishes (success or timeout).
- o_Timeout  out  1  result flag. Valid from o_Done; held until the next accepted i_Start.
- o_Time  out  CNT_W  averaged ticks. Valid from o_Done; held until the next accepted i_Start.

Behaviour:
- Reset: state=IDLE, all outputs 0, internal counters, sum and echo_d cleared. Reset mid-measurement aborts immediately with no o_Done.
- echo_d is i_Echo registered once. Echo edge (rise) = i_Echo & ~echo_d.
- States: IDLE, ARM, FIRE, GUARD, REPORT.
- IDLE:
  - i_Start=1 -> ARM next cycle.
  - Same transition clears sum, shot index, o_Time and o_Timeout.
- ARM:
  - Waits for i_Echo low.
  - i_Echo=0 in this cycle -> FIRE next cycle, tick counter t=0.
  - i_Echo held high for TIMEOUT_TICKS consecutive ARM cycles -> timeout abort.
- FIRE:
  - o_Fire=1; t increments each cycle; the first FIRE cycle has t=0.
  - Rise seen in a cycle with counter value t -> sum += t, go to GUARD.
  - No rise and t == TIMEOUT_TICKS-1 -> timeout abort.
  - Rise and timeout in the same cycle: the rise wins, and the shot is valid with value TIMEOUT_TICKS-1.
- GUARD:
  - o_Fire=0 for exactly GUARD_TICKS cycles.
  - Then, if shot index == SHOTS-1 -> REPORT; else shot index +1 -> ARM.
- REPORT:
  - One cycle. o_Done=1, o_Time = sum >> AVG_LOG2 (truncating), o_Timeout=0.
  - -> IDLE.
- Timeout abort: from ARM or FIRE, go to GUARD-like drain (o_Fire low, GUARD_TICKS), then a one-cycle REPORT with o_Done=1, o_Timeout=1, o_Time=0.
- Width rules:
  - sum is CNT_W+AVG_LOG2 bits, so it cannot overflow.
  - t never exceeds TIMEOUT_TICKS-1; no wrap.
- i_Start during any non-IDLE state (including REPORT) is dropped, not queued.
- Latency, rise to o_Done on the last shot: GUARD_TICKS+1 cycles.

Decomposition:
- Shared package (pulse_meter_pkg):
  - state encoding enum (IDLE/ARM/FIRE/GUARD/REPORT);
  - default CNT_W;
  - SHOTS derived constant.
- One natural sub-module: echo_edge_detector (registers i_Echo, outputs the one-cycle rise strobe). Reusable by the measurement front-ends.
- Everything else stays in this block.

Test Plan:
1. AVG_LOG2=2, echo rises at t=50 each shot -> four FIRE windows, four GUARD gaps of 10 low cycles, o_Done once, o_Time=50, o_Timeout=0.
2. Echo rises at t=10, 11, 12, 13 -> o_Time=11 (sum 46 >> 2, truncated).
3. Echo never rises, TIMEOUT_TICKS=1000 -> o_Fire high exactly 1000 cycles, then 10 low, o_Done with o_Timeout=1, o_Time=0.
4. i_Echo held high at start -> stays in ARM, o_Fire never asserts; timeout after 1000 cycles, o_Timeout=1. Separately, drop echo at cycle 5 -> FIRE begins the next cycle.
5. Rise exactly at t=999 with TIMEOUT_TICKS=1000 -> counted, o_Timeout=0, contributes 999 to the sum.
6. i_Rst asserted mid-FIRE of shot 2 -> next cycle o_Fire=0, o_Busy=0, no o_Done. Extra i_Start pulses during busy -> ignored. A fresh i_Start afterwards gives a normal result.
